// File: rtl/sudoku_board_ram_if.sv
// Bus bundle for sudoku_board_ram.
// Purpose: carries the access, clear-request and status signals between a
// requester (master) and the board RAM (slave).
// Signals:
//   ceb       access enable, active high
//   web       write enable, active low (1 = read)
//   addr      word address
//   d         write data
//   clr_start single-cycle request for a full-array clear
//   q         registered read data
//   q_valid   one-cycle pulse, q was updated by a read
//   busy      clear sweep in progress, accesses ignored
//   oor_err   one-cycle pulse, previous accepted access was out of range
interface sudoku_board_ram_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 7
);
  logic             ceb;
  logic             web;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] d;
  logic             clr_start;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic             oor_err;

  modport master (
    output ceb, web, addr, d, clr_start,
    input  q, q_valid, busy, oor_err
  );

  modport slave (
    input  ceb, web, addr, d, clr_start,
    output q, q_valid, busy, oor_err
  );
endinterface

// File: rtl/sudoku_board_ram.sv
// Single-port board-cell RAM with a built-in clear sweep.
// Purpose: stores one WIDTH-bit word per board cell (DEPTH cells). After
// reset, or on a clr_start request, a sequencer walks every cell writing 0
// and reports busy while doing so; user accesses are ignored meanwhile.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    sudoku_board_ram_if.slave (ceb, web, addr, d, clr_start in;
//          q, q_valid, busy, oor_err out)
// Parameters: WIDTH data width, DEPTH word count, AW address width
// (2**AW must exceed DEPTH so out-of-range addresses are representable).
module sudoku_board_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 81,
  parameter int AW    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  sudoku_board_ram_if.slave   bus
);

  // Index width sized to the array itself; the address may be wider.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;

  // The array has no reset; only the clear sweep zeroes it.
  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_range;
  logic             access;
  logic             mem_we;
  logic [IW-1:0]    mem_idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             oor_r;

  assign in_range = (bus.addr < DEPTH_A);
  // Out-of-range addresses are steered to cell 0 so the array index never
  // exceeds its bounds; the result is discarded for such accesses anyway.
  assign rd_idx   = in_range ? bus.addr[IW-1:0] : '0;

  // Sequencer state and sweep pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic and the single array write port, shared between the
  // sweep and user writes. A clr_start in IDLE wins over a same-cycle access.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    access    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = ptr;
    mem_wdata = '0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + IW'(1);
        end
      end
      IDLE: begin
        if (bus.clr_start) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else if (bus.ceb) begin
          access = 1'b1;
          if (!bus.web && in_range) begin
            mem_we    = 1'b1;
            mem_idx   = rd_idx;
            mem_wdata = bus.d;
          end
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // Registered read data and status pulses. q only changes on an accepted
  // read; out-of-range reads return all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
      oor_r     <= 1'b0;
    end else begin
      q_valid_r <= 1'b0;
      oor_r     <= 1'b0;
      if (access) begin
        oor_r <= !in_range;
        if (bus.web) begin
          q_valid_r <= 1'b1;
          q_r       <= in_range ? mem[rd_idx] : '1;
        end
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.oor_err = oor_r;
  assign bus.busy    = (state == CLEAR);

endmodule

// File: doc/sudoku_board_ram.md
SUDOKU_BOARD_RAM -- requirements
Module: sudoku_board_ram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 81, number of stored words (one per board cell).
REQ-003 The block SHALL have parameter AW, default 7, address width; AW SHALL satisfy 2**AW > DEPTH.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ceb  input  1  access enable, active high.
REQ-008 web  input  1  write enable, active low; 1 = read.
REQ-009 addr  input  AW  word address.
REQ-010 d  input  WIDTH  write data.
REQ-011 clr_start  input  1  request a full-array clear; single-cycle pulse.
REQ-012 q  output  WIDTH  registered read data.
REQ-013 q_valid  output  1  one-cycle pulse; q updated by a read this cycle.
REQ-014 busy  output  1  clear sequencer active; accesses ignored.
REQ-015 oor_err  output  1  one-cycle pulse; previous accepted access had addr >= DEPTH.

Function
REQ-016 The controller SHALL have two states, IDLE and CLEAR; busy = 1 exactly when in CLEAR.
REQ-017 In CLEAR, each cycle SHALL write 0 to mem[ptr] and increment ptr; ptr = DEPTH-1 written -> IDLE next edge; CLEAR lasts exactly DEPTH cycles.
REQ-018 IDLE with clr_start = 1 SHALL enter CLEAR with ptr = 0 on the next edge; any same-cycle ceb access is dropped (no write, no q_valid, no oor_err).
REQ-019 clr_start during CLEAR SHALL be ignored (no restart).
REQ-020 ceb during CLEAR SHALL be ignored: no array change, q holds, q_valid = 0, oor_err = 0.
REQ-021 Read (IDLE, ceb=1, web=1, addr < DEPTH): q <= mem[addr] and q_valid = 1 on the next edge (1-cycle latency).
REQ-022 Read with addr >= DEPTH: q <= all ones, q_valid = 1, oor_err = 1 on the next edge.
REQ-023 Write (IDLE, ceb=1, web=0, addr < DEPTH): mem[addr] <= d; q holds; q_valid = 0.
REQ-024 Write with addr >= DEPTH: no array change; oor_err = 1 next cycle; q holds.
REQ-025 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-026 With ceb = 0, q SHALL hold its last value and q_valid and oor_err SHALL be 0.
REQ-027 Back-to-back reads SHALL be accepted every cycle, with q_valid high continuously.

Reset
REQ-028 rst_n low SHALL asynchronously force q = 0, q_valid = 0, oor_err = 0, state = CLEAR, ptr = 0, busy = 1.
REQ-029 After rst_n release, the array SHALL be zeroed by the CLEAR sweep; busy falls DEPTH cycles later.
REQ-030 Reset asserted mid-CLEAR or mid-access SHALL abandon the operation and restart the sweep from ptr = 0.
REQ-031 The array itself SHALL NOT be reset directly; only the sweep clears it.

Verification
REQ-032 Reset release -> busy = 1 for exactly 81 cycles; then reading each of 0..80 -> q = 0x00, q_valid pulse each.
REQ-033 Write 0x05 to addr 40, read addr 40 next cycle -> q = 0x05, q_valid = 1, oor_err = 0.
REQ-034 Read addr 81 -> q = 0xFF, q_valid = 1, oor_err = 1; write 0x07 to addr 100 -> oor_err = 1, then reads of 0..80 unchanged.
REQ-035 Fill all cells with 0x09, pulse clr_start together with a write of 0x03 to addr 0 -> write dropped; busy 81 cycles; all cells read 0x00.
REQ-036 Assert rst_n low at sweep cycle 30 for 2 cycles -> busy stays 1 and falls 81 cycles after release; reads during busy -> q_valid = 0.
REQ-037 Instance with WIDTH=4, DEPTH=16, AW=5: read addr 16 -> q = 0xF, oor_err = 1; sweep lasts 16 cycles.
